// File: rtl/xbar_prio_ctrl.sv
// ---------------------------------------------------------------------------
// xbar_prio_ctrl
//
// External priority controller for a full crossbar running with ExtPrio=1.
// It observes the master-side request/target/grant handshakes and keeps one
// registered priority pointer per target port. The crossbar uses these
// pointers as its rr_i input.
//
// Policy per target:
//   - The pointer advances round-robin past the requestor that was granted.
//   - A starving requestor (optional, gated by en_i) takes priority at its
//     target. A requestor starves after StarveThresh consecutive stalled
//     cycles.
//
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous, active-high reset
//   en_i      : starvation boost enable (counters run regardless)
//   req_i     : per-requestor request (same net as crossbar req_i)
//   add_i     : per-requestor target index
//   gnt_i     : per-requestor grant (crossbar gnt_o)
//   rr_o      : per-target highest-priority requestor index, registered
//   starve_o  : per-requestor starving flag, decoded from registered counters
// ---------------------------------------------------------------------------
module xbar_prio_ctrl #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned NumOut       = 4,
    parameter int unsigned StarveThresh = 8,
    parameter int unsigned CntWidth     = $clog2(StarveThresh + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     en_i,
    input  logic [NumIn-1:0]                         req_i,
    input  logic [NumIn-1:0][$clog2(NumOut)-1:0]     add_i,
    input  logic [NumIn-1:0]                         gnt_i,
    output logic [NumOut-1:0][$clog2(NumIn)-1:0]     rr_o,
    output logic [NumIn-1:0]                         starve_o
);

    localparam int unsigned IdxW = $clog2(NumIn);
    localparam int          NIn  = int'(NumIn);
    localparam int          NOut = int'(NumOut);
    localparam logic [CntWidth-1:0] Thresh = CntWidth'(StarveThresh);

    logic [NumIn-1:0][CntWidth-1:0] wait_cnt_q, wait_cnt_d;
    logic [NumOut-1:0][IdxW-1:0]    ptr_q, ptr_d;

    // Starvation is decoded purely from the registered counters.
    always_comb begin
        starve_o = '0;
        for (int j = 0; j < NIn; j++) begin
            starve_o[j] = (wait_cnt_q[j] == Thresh);
        end
    end

    // Wait counters: cleared on withdrawal or grant, saturating otherwise.
    // An out-of-range target still counts here.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int j = 0; j < NIn; j++) begin
            if (!req_i[j] || gnt_i[j]) begin
                wait_cnt_d[j] = '0;
            end else if (wait_cnt_q[j] != Thresh) begin
                wait_cnt_d[j] = wait_cnt_q[j] + CntWidth'(1);
            end
        end
    end

    // Per-target pointer: boost beats advance, and advance beats hold.
    // Ascending scans keep the first hit, so the lowest index wins.
    always_comb begin
        logic boost_hit;
        logic adv_hit;
        ptr_d = ptr_q;
        for (int k = 0; k < NOut; k++) begin
            boost_hit = 1'b0;
            adv_hit   = 1'b0;
            for (int j = 0; j < NIn; j++) begin
                if (!boost_hit && en_i && starve_o[j] && req_i[j] && !gnt_i[j]
                    && (int'(add_i[j]) == k)) begin
                    boost_hit = 1'b1;
                    ptr_d[k]  = IdxW'(j);
                end
            end
            if (!boost_hit) begin
                for (int j = 0; j < NIn; j++) begin
                    if (!adv_hit && req_i[j] && gnt_i[j] && (int'(add_i[j]) == k)) begin
                        adv_hit  = 1'b1;
                        ptr_d[k] = IdxW'((j + 1) % NIn);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign rr_o = ptr_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        assert (NumIn >= 2) else $error("xbar_prio_ctrl: NumIn must be >= 2");
        assert (NumOut >= 2) else $error("xbar_prio_ctrl: NumOut must be >= 2");
        assert (StarveThresh >= 1) else $error("xbar_prio_ctrl: StarveThresh must be >= 1");
        if (!rst_i) begin
            assert ((gnt_i & ~req_i) == '0)
                else $error("xbar_prio_ctrl: grant without request");
        end
    end
`endif

endmodule

// File: tb/tb_xbar_prio_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for xbar_prio_ctrl (NumIn=4, NumOut=4, StarveThresh=8).
// Directed scenarios followed by a randomized phase. Every cycle is compared
// against a behavioural model that holds per-requestor wait counts and
// per-target pointers as plain integers.
// ---------------------------------------------------------------------------
module tb_xbar_prio_ctrl;

    localparam int NI  = 4;
    localparam int NO  = 4;
    localparam int THR = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NI-1:0]    req;
    logic [NI-1:0][1:0] add;
    logic [NI-1:0]    gnt;
    logic [NO-1:0][1:0] rr;
    logic [NI-1:0]    starve;

    int total = 0;
    int bad   = 0;

    // Model state.
    int m_wait[NI];
    int m_ptr[NO];

    xbar_prio_ctrl #(
        .NumIn(NI), .NumOut(NO), .StarveThresh(THR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .add_i(add),
        .gnt_i(gnt), .rr_o(rr), .starve_o(starve)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: compute the model's next state from the inputs
    // being applied, then compare every output after the edge.
    task automatic cycle();
        int nw[NI];
        int np[NO];
        int cand[$];
        for (int j = 0; j < NI; j++) begin
            if (!req[j] || gnt[j]) nw[j] = 0;
            else nw[j] = (m_wait[j] >= THR) ? THR : m_wait[j] + 1;
        end
        for (int k = 0; k < NO; k++) begin
            np[k] = m_ptr[k];
            cand.delete();
            for (int j = 0; j < NI; j++)
                if (en && m_wait[j] == THR && req[j] && !gnt[j] && int'(add[j]) == k)
                    cand.push_back(j);
            if (cand.size() > 0) begin
                np[k] = cand[0];
            end else begin
                for (int j = NI - 1; j >= 0; j--)
                    if (req[j] && gnt[j] && int'(add[j]) == k) np[k] = (j + 1) % NI;
            end
        end
        if (rst) begin
            for (int j = 0; j < NI; j++) nw[j] = 0;
            for (int k = 0; k < NO; k++) np[k] = 0;
        end
        @(posedge clk);
        #1;
        m_wait = nw;
        m_ptr  = np;
        for (int k = 0; k < NO; k++) check($sformatf("model_rr%0d", k), 32'(rr[k]), 32'(m_ptr[k]));
        for (int j = 0; j < NI; j++)
            check($sformatf("model_starve%0d", j), 32'(starve[j]), 32'(m_wait[j] == THR));
    endtask

    task automatic idle();
        req = '0; gnt = '0; add = '0;
    endtask

    initial begin
        logic [NI-1:0] r;
        for (int j = 0; j < NI; j++) m_wait[j] = 0;
        for (int k = 0; k < NO; k++) m_ptr[k] = 0;
        en = 1'b1;
        rst = 1'b1;

        // 1. Reset with random traffic, then quiet.
        for (int i = 0; i < 2; i++) begin
            r = NI'($urandom);
            req = r; gnt = r & NI'($urandom); add = 8'($urandom);
            cycle();
        end
        check("rst_rr", 32'(rr), 0);
        check("rst_starve", 32'(starve), 0);
        rst = 1'b0;
        idle();
        cycle();
        check("post_rst_rr", 32'(rr), 0);

        // 2. Advance and wrap on target 1.
        req[2] = 1; add[2] = 2'd1; gnt[2] = 1;
        cycle();
        check("adv_rr1", 32'(rr[1]), 3);
        idle();
        req[3] = 1; add[3] = 2'd1; gnt[3] = 1;
        cycle();
        check("wrap_rr1", 32'(rr[1]), 0);
        check("wrap_rr0", 32'(rr[0]), 0);
        check("wrap_rr2", 32'(rr[2]), 0);
        check("wrap_rr3", 32'(rr[3]), 0);

        // 3. Starvation boost on target 2. Move rr[2] away from 0 first.
        idle();
        req[1] = 1; add[1] = 2'd2; gnt[1] = 1;
        cycle();
        check("pre_boost_rr2", 32'(rr[2]), 2);
        idle();
        req[0] = 1; add[0] = 2'd2;
        for (int i = 1; i <= THR; i++) begin
            cycle();
            check("starve_ramp", 32'(starve[0]), 32'(i == THR));
        end
        check("boost_not_yet_rr2", 32'(rr[2]), 2);
        cycle();
        check("boost_rr2", 32'(rr[2]), 0);
        gnt[0] = 1;
        cycle();
        check("boost_release_starve0", 32'(starve[0]), 0);
        check("boost_release_rr2", 32'(rr[2]), 1);

        // 4. Boost disabled: counter saturates, pointer moves only on handshakes.
        idle();
        en = 1'b0;
        cycle();
        req[0] = 1; add[0] = 2'd2;
        for (int i = 1; i <= THR + 20; i++) begin
            cycle();
            check("noboost_starve0", 32'(starve[0]), 32'(i >= THR));
            check("noboost_rr2", 32'(rr[2]), 1);
        end
        req[3] = 1; add[3] = 2'd2; gnt[3] = 1;
        cycle();
        check("noboost_hs_rr2", 32'(rr[2]), 0);
        check("noboost_hold_starve0", 32'(starve[0]), 1);

        // 5. Boost beats a same-cycle handshake; lowest starving index wins.
        idle();
        cycle();
        en = 1'b1;
        req[1] = 1; add[1] = 2'd0;
        req[3] = 1; add[3] = 2'd0;
        for (int i = 0; i < THR; i++) cycle();
        check("sim_starve", 32'(starve), 32'b1010);
        req[2] = 1; add[2] = 2'd0; gnt[2] = 1;
        cycle();
        check("sim_rr0", 32'(rr[0]), 1);

        // 6a. Withdrawal clears the counter.
        idle();
        cycle();
        req[1] = 1; add[1] = 2'd1;
        for (int i = 0; i < 5; i++) cycle();
        req[1] = 0;
        cycle();
        check("withdraw_starve1", 32'(starve[1]), 0);
        req[1] = 1;
        for (int i = 0; i < THR - 1; i++) cycle();
        check("withdraw_restall_starve1", 32'(starve[1]), 0);

        // 6b. Mid-operation reset.
        idle();
        req[1] = 1; add[1] = 2'd3; gnt[1] = 1;
        cycle();
        check("pre_rst_rr3", 32'(rr[3]), 2);
        idle();
        req[0] = 1; add[0] = 2'd1;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        cycle();
        check("midrst_rr3", 32'(rr[3]), 0);
        check("midrst_starve", 32'(starve), 0);
        rst = 1'b0;
        for (int i = 0; i < THR - 1; i++) cycle();
        check("midrst_cnt_cleared", 32'(starve[0]), 0);

        // Randomized phase: sparse grants so starvation occurs regularly.
        for (int i = 0; i < 2000; i++) begin
            r   = NI'($urandom);
            req = r;
            gnt = r & NI'($urandom) & NI'($urandom);
            add = 8'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
